// File: rtl/tiny16_exec_stage.sv
// rtl/tiny16_exec_stage.sv - Tiny16 execute/writeback stage with result forwarding and iterative multiply
module tiny16_exec_stage (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_op_valid,
    input  logic [2:0]  i_op_code,
    input  logic [1:0]  i_op_dst,
    input  logic [1:0]  i_op_srca,
    input  logic [1:0]  i_op_srcb,
    output logic        o_op_ready,
    input  logic [15:0] i_opa,
    input  logic [15:0] i_opb,
    output logic        o_rf_wr_n,
    output logic [1:0]  o_rf_address_wr,
    output logic [15:0] o_rf_data,
    output logic        o_flag_z,
    output logic        o_flag_c
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    // execute register
    logic        r_ex_valid;
    logic [2:0]  r_ex_op;
    logic [1:0]  r_ex_dst;
    logic [1:0]  r_ex_srca;
    logic [1:0]  r_ex_srcb;

    // writeback register (drives the register file directly)
    logic        r_wb_valid;
    logic [1:0]  r_wb_dst;
    logic [15:0] r_wb_data;
    logic        r_flag_z;
    logic        r_flag_c;

    // retired register: the result written at the previous edge
    logic        r_ret_valid;
    logic [1:0]  r_ret_dst;
    logic [15:0] r_ret_data;

    // multiplier state
    logic        r_busy;
    logic [4:0]  r_mul_count;
    logic [15:0] r_mul_mcand;
    logic [15:0] r_mul_mplr;
    logic [15:0] r_mul_acc;
    logic [1:0]  r_mul_dst;

    logic        w_issue;
    logic        w_ex_single;
    logic        w_ex_mul;
    logic        w_mul_step;
    logic        w_mul_done;
    logic [15:0] w_mul_acc_next;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [16:0] w_res;

    assign o_op_ready      = ~r_busy;
    assign w_issue         = i_op_valid & ~r_busy;
    assign w_ex_single     = r_ex_valid && (r_ex_op != OP_MUL);
    assign w_ex_mul        = r_ex_valid && (r_ex_op == OP_MUL);
    assign w_mul_step      = (r_mul_count != 5'd0);
    assign w_mul_done      = w_mul_step && (r_mul_count == 5'd1);
    assign w_mul_acc_next  = r_mul_acc + (r_mul_mplr[0] ? r_mul_mcand : 16'd0);
    assign o_rf_wr_n       = ~r_wb_valid;
    assign o_rf_address_wr = r_wb_dst;
    assign o_rf_data       = r_wb_data;
    assign o_flag_z        = r_flag_z;
    assign o_flag_c        = r_flag_c;

    // operand forwarding: the result being written now beats the one written last edge,
    // since the register file read at the write edge still returns the old value
    always_comb begin
        w_a = i_opa;
        w_b = i_opb;
        if (r_wb_valid && (r_wb_dst == r_ex_srca))
            w_a = r_wb_data;
        else if (r_ret_valid && (r_ret_dst == r_ex_srca))
            w_a = r_ret_data;
        if (r_wb_valid && (r_wb_dst == r_ex_srcb))
            w_b = r_wb_data;
        else if (r_ret_valid && (r_ret_dst == r_ex_srcb))
            w_b = r_ret_data;
    end

    // single-cycle ALU; bit 16 is the carry/borrow flag
    always_comb begin
        w_res = 17'd0;
        case (r_ex_op)
            OP_ADD:  w_res = {1'b0, w_a} + {1'b0, w_b};
            OP_SUB:  w_res = {1'b0, w_a} - {1'b0, w_b};
            OP_AND:  w_res = {1'b0, w_a & w_b};
            OP_OR:   w_res = {1'b0, w_a | w_b};
            OP_XOR:  w_res = {1'b0, w_a ^ w_b};
            OP_SHL:  w_res = {1'b0, w_a << w_b[3:0]};
            OP_MOV:  w_res = {1'b0, w_b};
            default: w_res = 17'd0;
        endcase
    end

    // issue: capture the decoded op; dropped while a multiply holds the stage
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ex_valid <= 1'b0;
            r_ex_op    <= 3'd0;
            r_ex_dst   <= 2'd0;
            r_ex_srca  <= 2'd0;
            r_ex_srcb  <= 2'd0;
        end else begin
            r_ex_valid <= w_issue;
            if (w_issue) begin
                r_ex_op   <= i_op_code;
                r_ex_dst  <= i_op_dst;
                r_ex_srca <= i_op_srca;
                r_ex_srcb <= i_op_srcb;
            end
        end
    end

    // multiply: busy from the accepting edge until the 16th shift-add step completes
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_busy      <= 1'b0;
            r_mul_count <= 5'd0;
            r_mul_mcand <= 16'd0;
            r_mul_mplr  <= 16'd0;
            r_mul_acc   <= 16'd0;
            r_mul_dst   <= 2'd0;
        end else begin
            if (w_issue && (i_op_code == OP_MUL))
                r_busy <= 1'b1;
            else if (w_mul_done)
                r_busy <= 1'b0;
            if (w_ex_mul) begin
                r_mul_mcand <= w_a;
                r_mul_mplr  <= w_b;
                r_mul_acc   <= 16'd0;
                r_mul_count <= 5'd16;
                r_mul_dst   <= r_ex_dst;
            end else if (w_mul_step) begin
                r_mul_acc   <= w_mul_acc_next;
                r_mul_mcand <= r_mul_mcand << 1;
                r_mul_mplr  <= r_mul_mplr >> 1;
                r_mul_count <= r_mul_count - 5'd1;
            end
        end
    end

    // writeback: strobe for one cycle per result; address/data/flags hold until the next result
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wb_valid <= 1'b0;
            r_wb_dst   <= 2'd0;
            r_wb_data  <= 16'd0;
            r_flag_z   <= 1'b0;
            r_flag_c   <= 1'b0;
        end else if (w_ex_single) begin
            r_wb_valid <= 1'b1;
            r_wb_dst   <= r_ex_dst;
            r_wb_data  <= w_res[15:0];
            r_flag_z   <= (w_res[15:0] == 16'd0);
            r_flag_c   <= w_res[16];
        end else if (w_mul_done) begin
            r_wb_valid <= 1'b1;
            r_wb_dst   <= r_mul_dst;
            r_wb_data  <= w_mul_acc_next;
            r_flag_z   <= (w_mul_acc_next == 16'd0);
            r_flag_c   <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
        end
    end

    // retired: keep the just-written result one more cycle for distance-2 forwarding
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ret_valid <= 1'b0;
            r_ret_dst   <= 2'd0;
            r_ret_data  <= 16'd0;
        end else begin
            r_ret_valid <= r_wb_valid;
            r_ret_dst   <= r_wb_dst;
            r_ret_data  <= r_wb_data;
        end
    end

endmodule

// File: tb/tb_tiny16_exec_stage.sv
// tb/tb_tiny16_exec_stage.sv - scoreboard bench for tiny16_exec_stage
module tb_tiny16_exec_stage;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, SHL = 3'd5, MUL = 3'd6, MOV = 3'd7;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [1:0]  op_dst, op_srca, op_srcb;
    logic [15:0] opa, opb;
    logic        op_ready, rf_wr_n, flag_z, flag_c;
    logic [1:0]  rf_address_wr;
    logic [15:0] rf_data;

    typedef struct {
        int          cyc;
        logic [1:0]  addr;
        logic [15:0] data;
        logic        z;
        logic        c;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    int   t0;

    tiny16_exec_stage dut (
        .i_clk(clk), .i_reset(rst), .i_op_valid(op_valid), .i_op_code(op_code),
        .i_op_dst(op_dst), .i_op_srca(op_srca), .i_op_srcb(op_srcb), .o_op_ready(op_ready),
        .i_opa(opa), .i_opb(opb), .o_rf_wr_n(rf_wr_n), .o_rf_address_wr(rf_address_wr),
        .o_rf_data(rf_data), .o_flag_z(flag_z), .o_flag_c(flag_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference ALU: {carry, result}
    function automatic logic [16:0] model(input logic [2:0] oc, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        case (oc)
            ADD:     model = {1'b0, a} + {1'b0, b};
            SUB:     model = {1'b0, a} - {1'b0, b};
            AND_:    model = {1'b0, a & b};
            OR_:     model = {1'b0, a | b};
            XOR_:    model = {1'b0, a ^ b};
            SHL:     model = {1'b0, a << b[3:0]};
            MUL:     begin p = a * b; model = {1'b0, p[15:0]}; end
            default: model = {1'b0, b};
        endcase
    endfunction

    task automatic push(input int c, input logic [1:0] ad, input logic [2:0] oc, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        logic [16:0] r;
        r = model(oc, a, b);
        e.cyc = c; e.addr = ad; e.data = r[15:0]; e.z = (r[15:0] == 16'd0); e.c = r[16];
        q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [2:0] oc, input logic [1:0] d, input logic [1:0] sa,
                         input logic [1:0] sb, input logic [15:0] a, input logic [15:0] b);
        op_valid = v; op_code = oc; op_dst = d; op_srca = sa; op_srcb = sb; opa = a; opb = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_n"}, rf_wr_n, 1'b1);
        check({tag, "_addr"}, rf_address_wr, 2'd0);
        check({tag, "_data"}, rf_data, 16'd0);
        check({tag, "_z"}, flag_z, 1'b0);
        check({tag, "_c"}, flag_c, 1'b0);
        check({tag, "_ready"}, op_ready, 1'b1);
    endtask

    // scoreboard: every write strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && rf_wr_n === 1'b0) begin
            exp_t e;
            tests++;
            assert (q.size() != 0) else begin
                failed++;
                $error("FAIL unexpected_write cycle=%0d addr=%0h data=%0h expected=no_write", cyc, rf_address_wr, rf_data);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", rf_address_wr, e.addr);
                check("wr_data", rf_data, e.data);
                check("wr_flag_z", flag_z, e.z);
                check("wr_flag_c", flag_c, e.c);
            end
        end
    end

    initial begin
        rst = 1'b1;
        op_valid = 1'b0; op_code = 3'd0; op_dst = 2'd0; op_srca = 2'd0; op_srcb = 2'd0;
        opa = 16'd0; opb = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        // ADD r1 = 3 + 4
        push(cyc + 2, 2'd1, ADD, 16'h0003, 16'h0004);
        drive(1'b1, ADD, 2'd1, 2'd0, 2'd0, 16'd0, 16'd0);
        drive(1'b0, ADD, 2'd0, 2'd0, 2'd0, 16'h0003, 16'h0004);
        idle(4);

        // SUB borrow then XOR to zero, back to back
        push(cyc + 2, 2'd2, SUB, 16'h0000, 16'h0001);
        drive(1'b1, SUB, 2'd2, 2'd0, 2'd1, 16'd0, 16'd0);
        push(cyc + 2, 2'd3, XOR_, 16'h00FF, 16'h00FF);
        drive(1'b1, XOR_, 2'd3, 2'd0, 2'd0, 16'h0000, 16'h0001);
        drive(1'b0, ADD, 2'd0, 2'd0, 2'd0, 16'h00FF, 16'h00FF);
        idle(4);

        // forwarding chain: distance 1 (wb), 2 (retired), 3 (register file)
        push(cyc + 2, 2'd1, ADD, 16'h0008, 16'h0008);
        drive(1'b1, ADD, 2'd1, 2'd2, 2'd3, 16'd0, 16'd0);
        push(cyc + 2, 2'd2, ADD, 16'h0010, 16'h0010);
        drive(1'b1, ADD, 2'd2, 2'd1, 2'd1, 16'h0008, 16'h0008);
        push(cyc + 2, 2'd3, MOV, 16'h0000, 16'h0010);
        drive(1'b1, MOV, 2'd3, 2'd0, 2'd1, 16'h0000, 16'h0000);
        push(cyc + 2, 2'd0, AND_, 16'h0010, 16'h0010);
        drive(1'b1, AND_, 2'd0, 2'd1, 2'd1, 16'h0000, 16'h0000);
        drive(1'b0, ADD, 2'd0, 2'd0, 2'd0, 16'h0010, 16'h0010);
        idle(4);

        // OR just before a MUL still writes; ops offered while busy are dropped
        push(cyc + 2, 2'd2, OR_, 16'h0F00, 16'h00F0);
        drive(1'b1, OR_, 2'd2, 2'd0, 2'd0, 16'd0, 16'd0);
        t0 = cyc;
        push(t0 + 18, 2'd1, MUL, 16'h0123, 16'h0010);
        drive(1'b1, MUL, 2'd1, 2'd0, 2'd3, 16'h0F00, 16'h00F0);
        check("mul_ready_t1", op_ready, 1'b0);
        drive(1'b1, ADD, 2'd0, 2'd0, 2'd0, 16'h0123, 16'h0010);
        for (int k = 2; k <= 17; k++) begin
            check($sformatf("mul_ready_t%0d", k), op_ready, 1'b0);
            drive(1'b1, XOR_, 2'(k), 2'd0, 2'd0, 16'($urandom), 16'($urandom));
        end
        check("mul_ready_t18", op_ready, 1'b1);
        check("mul_ready_cycle", cyc, t0 + 18);
        idle(4);

        // MUL aborted by reset in mid-iteration
        drive(1'b1, MUL, 2'd2, 2'd0, 2'd0, 16'd0, 16'd0);
        drive(1'b0, ADD, 2'd0, 2'd0, 2'd0, 16'hFFFF, 16'hFFFF);
        idle(7);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        idle(30);
        check_reset_outputs("after_abort");

        // SHL uses only opb[3:0]
        push(cyc + 2, 2'd3, SHL, 16'h8001, 16'h0011);
        drive(1'b1, SHL, 2'd3, 2'd0, 2'd0, 16'd0, 16'd0);
        drive(1'b0, ADD, 2'd0, 2'd0, 2'd0, 16'h8001, 16'h0011);
        idle(3);

        // zero flag holds after the strobe ends
        push(cyc + 2, 2'd0, XOR_, 16'h5555, 16'h5555);
        drive(1'b1, XOR_, 2'd0, 2'd0, 2'd0, 16'd0, 16'd0);
        drive(1'b0, ADD, 2'd0, 2'd0, 2'd0, 16'h5555, 16'h5555);
        idle(5);
        check("hold_wr_n", rf_wr_n, 1'b1);
        check("hold_flag_z", flag_z, 1'b1);
        check("hold_flag_c", flag_c, 1'b0);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
